// File: rtl/iwht_pkg.sv
// Shared definitions for the inverse 4x4 Walsh-Hadamard transform block:
// FSM state encoding, default coefficient width, internal width growth,
// rounding constant and a small index helper.
package iwht_pkg;

  // Default width of signed coefficients and results.
  localparam int COEF_W_DEF = 16;

  // Growth after the vertical pass (sum of four terms): COEF_W+2.
  localparam int T_EXTRA    = 2;

  // Growth inside the horizontal pass (four more terms plus rounding): COEF_W+4.
  localparam int EXT_EXTRA  = 4;

  // Rounding offset added to the DC term before the final divide by 8.
  localparam int RND_C      = 3;

  // Final normalisation shift (divide by 8).
  localparam int OUT_SH     = 3;

  // Number of coefficients in one 4x4 block.
  localparam int NCOEF      = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_VERT = 2'd1,
    ST_HORZ = 2'd2
  } state_t;

  // Raster index of element (row, col) in the 4x4 block.
  function automatic logic [3:0] f_idx(input logic [1:0] row, input logic [1:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/iwht_transform_if.sv
// Block-transfer interface for iwht_transform: a start strobe with the
// 16-coefficient input block, and the result block with busy/done status.
interface iwht_transform_if #(
  parameter int COEF_W = iwht_pkg::COEF_W_DEF
);

  logic                 start;
  logic [16*COEF_W-1:0] in;
  logic [16*COEF_W-1:0] out;
  logic                 busy;
  logic                 done;

  // Requester side: issues blocks, observes results.
  modport master (
    output start,
    output in,
    input  out,
    input  busy,
    input  done
  );

  // Transform side.
  modport slave (
    input  start,
    input  in,
    output out,
    output busy,
    output done
  );

endinterface

// File: rtl/iwht_butterfly.sv
// Combinational 4-point Hadamard butterfly. Shared between the column
// (vertical) and row (horizontal) passes of the inverse transform; the
// caller sizes W so that no intermediate sum can overflow.
module iwht_butterfly #(
  parameter int W = 20
) (
  input  logic signed [W-1:0] i_x0,
  input  logic signed [W-1:0] i_x1,
  input  logic signed [W-1:0] i_x2,
  input  logic signed [W-1:0] i_x3,
  output logic signed [W-1:0] o_y0,
  output logic signed [W-1:0] o_y1,
  output logic signed [W-1:0] o_y2,
  output logic signed [W-1:0] o_y3
);

  logic signed [W-1:0] w_a0;
  logic signed [W-1:0] w_a1;
  logic signed [W-1:0] w_a2;
  logic signed [W-1:0] w_a3;

  // Two butterfly stages: outer/inner pair sums and differences, then recombine.
  always_comb begin
    w_a0 = i_x0 + i_x3;
    w_a1 = i_x1 + i_x2;
    w_a2 = i_x1 - i_x2;
    w_a3 = i_x0 - i_x3;
    o_y0 = w_a0 + w_a1;
    o_y1 = w_a3 + w_a2;
    o_y2 = w_a0 - w_a1;
    o_y3 = w_a3 - w_a2;
  end

endmodule

// File: rtl/iwht_transform.sv
// Inverse 4x4 Walsh-Hadamard transform.
// A start strobe captures a 16-coefficient block; four column passes (VERT)
// fill an exact COEF_W+2 intermediate buffer, then four row passes (HORZ)
// add the rounding offset, divide by 8 and write the result block. A single
// combinational butterfly is time-shared by both passes.
// Build option: define IWHT_SAT_EN to saturate results to the signed COEF_W
// range; otherwise results wrap to their low COEF_W bits.
module iwht_transform
  import iwht_pkg::*;
#(
  parameter int COEF_W = COEF_W_DEF
) (
  input logic             clk,
  input logic             rst,
  iwht_transform_if.slave bus
);

  localparam int T_W   = COEF_W + T_EXTRA;
  localparam int EXT_W = COEF_W + EXT_EXTRA;

`ifdef IWHT_SAT_EN
  localparam logic signed [EXT_W-1:0] SAT_MAX = EXT_W'((2 ** (COEF_W - 1)) - 1);
  localparam logic signed [EXT_W-1:0] SAT_MIN = EXT_W'(-(2 ** (COEF_W - 1)));
`endif

  state_t                   r_state;
  logic [1:0]               r_cnt;
  logic                     r_busy;
  logic                     r_done;

  logic signed [COEF_W-1:0] r_c   [NCOEF];
  logic signed [T_W-1:0]    r_t   [NCOEF];
  logic signed [COEF_W-1:0] r_out [NCOEF];

  logic signed [EXT_W-1:0]  w_x0;
  logic signed [EXT_W-1:0]  w_x1;
  logic signed [EXT_W-1:0]  w_x2;
  logic signed [EXT_W-1:0]  w_x3;
  logic signed [EXT_W-1:0]  w_y0;
  logic signed [EXT_W-1:0]  w_y1;
  logic signed [EXT_W-1:0]  w_y2;
  logic signed [EXT_W-1:0]  w_y3;
  logic                     w_last;

  // Divide by 8 (arithmetic, floors toward -inf) and fit into COEF_W bits.
  function automatic logic signed [COEF_W-1:0] f_clip(input logic signed [EXT_W-1:0] v);
    logic signed [EXT_W-1:0] sh;
    sh = v >>> OUT_SH;
`ifdef IWHT_SAT_EN
    if (sh > SAT_MAX) begin
      return COEF_W'(SAT_MAX);
    end else if (sh < SAT_MIN) begin
      return COEF_W'(SAT_MIN);
    end else begin
      return COEF_W'(sh);
    end
`else
    return COEF_W'(sh);
`endif
  endfunction

  assign w_last = (r_cnt == 2'd3);

  // Butterfly operand select: column cnt of the input block, or row cnt of the
  // intermediate block with the rounding offset folded into the DC term.
  always_comb begin
    w_x0 = '0;
    w_x1 = '0;
    w_x2 = '0;
    w_x3 = '0;
    unique case (r_state)
      ST_VERT: begin
        w_x0 = EXT_W'(r_c[f_idx(2'd0, r_cnt)]);
        w_x1 = EXT_W'(r_c[f_idx(2'd1, r_cnt)]);
        w_x2 = EXT_W'(r_c[f_idx(2'd2, r_cnt)]);
        w_x3 = EXT_W'(r_c[f_idx(2'd3, r_cnt)]);
      end
      ST_HORZ: begin
        w_x0 = EXT_W'(r_t[f_idx(r_cnt, 2'd0)]) + EXT_W'(RND_C);
        w_x1 = EXT_W'(r_t[f_idx(r_cnt, 2'd1)]);
        w_x2 = EXT_W'(r_t[f_idx(r_cnt, 2'd2)]);
        w_x3 = EXT_W'(r_t[f_idx(r_cnt, 2'd3)]);
      end
      default: ;
    endcase
  end

  iwht_butterfly #(
    .W (EXT_W)
  ) u_bfly (
    .i_x0 (w_x0),
    .i_x1 (w_x1),
    .i_x2 (w_x2),
    .i_x3 (w_x3),
    .o_y0 (w_y0),
    .o_y1 (w_y1),
    .o_y2 (w_y2),
    .o_y3 (w_y3)
  );

  // Sequencer: IDLE -> 4 column passes -> 4 row passes -> IDLE with a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 2'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_state <= ST_VERT;
            r_cnt   <= 2'd0;
            r_busy  <= 1'b1;
          end
        end
        ST_VERT: begin
          if (w_last) begin
            r_state <= ST_HORZ;
            r_cnt   <= 2'd0;
          end else begin
            r_cnt <= r_cnt + 2'd1;
          end
        end
        ST_HORZ: begin
          if (w_last) begin
            r_state <= ST_IDLE;
            r_cnt   <= 2'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 2'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= 2'd0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Block buffers: input capture, exact column results, final row results.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NCOEF; k++) begin
        r_c[k]   <= '0;
        r_t[k]   <= '0;
        r_out[k] <= '0;
      end
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            for (int k = 0; k < NCOEF; k++) begin
              r_c[k] <= bus.in[COEF_W*k +: COEF_W];
            end
          end
        end
        ST_VERT: begin
          r_t[f_idx(2'd0, r_cnt)] <= T_W'(w_y0);
          r_t[f_idx(2'd1, r_cnt)] <= T_W'(w_y1);
          r_t[f_idx(2'd2, r_cnt)] <= T_W'(w_y2);
          r_t[f_idx(2'd3, r_cnt)] <= T_W'(w_y3);
        end
        ST_HORZ: begin
          r_out[f_idx(2'd0, r_cnt)] <= f_clip(w_y0);
          r_out[f_idx(2'd1, r_cnt)] <= f_clip(w_y1);
          r_out[f_idx(2'd2, r_cnt)] <= f_clip(w_y2);
          r_out[f_idx(2'd3, r_cnt)] <= f_clip(w_y3);
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;

  for (genvar g = 0; g < NCOEF; g++) begin : g_out
    assign bus.out[COEF_W*g +: COEF_W] = r_out[g];
  end

endmodule

// File: tb/tb_iwht_transform.sv
// Self-checking bench for iwht_transform: directed timing/boundary cases plus
// randomized blocks against a matrix-form reference of the inverse 4x4 WHT.
// Honours IWHT_SAT_EN to select the expected saturation/wrap behaviour.
module tb_iwht_transform;

  localparam int CW = 16;
  typedef logic [16*CW-1:0] blk_t;

  // Hadamard basis in the row order produced by the butterfly.
  localparam int H [4][4] = '{'{1, 1, 1, 1}, '{1, 1, -1, -1}, '{1, -1, -1, 1}, '{1, -1, 1, -1}};

  logic clk = 1'b0;
  logic rst;

  int n_pass = 0;
  int n_chk  = 0;
  int n_fail = 0;

  iwht_transform_if #(.COEF_W(CW)) bus ();

  iwht_transform #(.COEF_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input blk_t obs, input blk_t exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // out[4j+i] = round( sum_k sum_m H[j][k] * H[i][m] * c[4m+k] / 8 )
  function automatic blk_t ref_iwht(input blk_t v);
    int c [16];
    int s;
    logic signed [CW-1:0] o;
    blk_t r;
    r = '0;
    for (int k = 0; k < 16; k++) c[k] = int'($signed(v[CW*k +: CW]));
    for (int j = 0; j < 4; j++) begin
      for (int i = 0; i < 4; i++) begin
        s = 0;
        for (int m = 0; m < 4; m++)
          for (int k = 0; k < 4; k++)
            s += H[j][k] * H[i][m] * c[4*m+k];
        s = (s + 3) >>> 3;
`ifdef IWHT_SAT_EN
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
`endif
        o = s[CW-1:0];
        r[CW*(4*j+i) +: CW] = o;
      end
    end
    return r;
  endfunction

  function automatic blk_t all_val(input int val);
    blk_t r;
    for (int k = 0; k < 16; k++) r[CW*k +: CW] = CW'(val);
    return r;
  endfunction

  function automatic blk_t rand_blk(input int mode);
    blk_t r;
    for (int k = 0; k < 16; k++) begin
      case (mode == 0 ? 0 : int'($urandom_range(0, 3)))
        1:       r[CW*k +: CW] = 16'h7FFF;
        2:       r[CW*k +: CW] = 16'h8000;
        default: r[CW*k +: CW] = CW'($urandom);
      endcase
    end
    return r;
  endfunction

  // Full transaction from cycle 0 (start) to cycle 10 (done gone again).
  task automatic run_xform(input string tag, input blk_t v);
    blk_t exp;
    exp = ref_iwht(v);
    bus.in    = v;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      chk({tag, "_busy"}, blk_t'(bus.busy), blk_t'(1'b1));
      chk({tag, "_nodone"}, blk_t'(bus.done), blk_t'(1'b0));
      tick();
    end
    chk({tag, "_done9"}, blk_t'(bus.done), blk_t'(1'b1));
    chk({tag, "_idle9"}, blk_t'(bus.busy), blk_t'(1'b0));
    chk({tag, "_out"}, bus.out, exp);
    tick();
    chk({tag, "_done_pulse"}, blk_t'(bus.done), blk_t'(1'b0));
  endtask

  initial begin
    blk_t a;
    blk_t b;
    blk_t v;

    bus.start = 1'b0;
    bus.in    = '0;
    rst       = 1'b1;
    tick();
    tick();
    chk("rst_busy", blk_t'(bus.busy), blk_t'(1'b0));
    chk("rst_done", blk_t'(bus.done), blk_t'(1'b0));
    chk("rst_out", bus.out, '0);
    rst = 1'b0;
    tick();

    // All-zero block
    run_xform("zero", '0);
    chk("zero_const", bus.out, '0);

    // Single DC coefficient of +8 and -8
    v = '0;
    v[CW-1:0] = 16'sd8;
    run_xform("dc_p8", v);
    chk("dc_p8_const", bus.out, all_val(1));
    v[CW-1:0] = -16'sd8;
    run_xform("dc_m8", v);
    chk("dc_m8_const", bus.out, all_val(-1));

    // Full-scale positive block
    run_xform("max", all_val(32767));
`ifdef IWHT_SAT_EN
    chk("max_out0", blk_t'(bus.out[CW-1:0]), blk_t'(16'h7FFF));
`else
    chk("max_out0", blk_t'(bus.out[CW-1:0]), blk_t'(16'hFFFE));
`endif
    chk("max_rest", blk_t'(bus.out[16*CW-1:CW]), '0);

    // Start re-pulsed in cycle 4 while busy must be ignored
    a = rand_blk(0);
    b = rand_blk(0);
    bus.in    = a;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    bus.in    = b;
    bus.start = 1'b1;
    chk("ign_busy4", blk_t'(bus.busy), blk_t'(1'b1));
    tick();
    bus.start = 1'b0;
    for (int c = 5; c <= 8; c++) begin
      chk("ign_nodone", blk_t'(bus.done), blk_t'(1'b0));
      tick();
    end
    chk("ign_done9", blk_t'(bus.done), blk_t'(1'b1));
    chk("ign_out", bus.out, ref_iwht(a));
    for (int c = 10; c <= 12; c++) begin
      tick();
      chk("ign_no_extra_done", blk_t'(bus.done), blk_t'(1'b0));
    end

    // Reset in cycle 6 aborts the transform
    a = rand_blk(0);
    bus.in    = a;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c < 6; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", blk_t'(bus.busy), blk_t'(1'b0));
    chk("abort_out", bus.out, '0);
    for (int c = 7; c <= 20; c++) begin
      chk("abort_nodone", blk_t'(bus.done), blk_t'(1'b0));
      tick();
    end
    run_xform("after_abort", rand_blk(1));

    // Back-to-back: second start in the done cycle
    a = rand_blk(0);
    b = rand_blk(1);
    bus.in    = a;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c <= 8; c++) tick();
    chk("b2b_done1", blk_t'(bus.done), blk_t'(1'b1));
    chk("b2b_out1", bus.out, ref_iwht(a));
    bus.in    = b;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      chk("b2b_busy2", blk_t'(bus.busy), blk_t'(1'b1));
      chk("b2b_nodone2", blk_t'(bus.done), blk_t'(1'b0));
      tick();
    end
    chk("b2b_done2", blk_t'(bus.done), blk_t'(1'b1));
    chk("b2b_out2", bus.out, ref_iwht(b));
    tick();

    // Randomized blocks, mixing uniform values with full-scale extremes
    for (int n = 0; n < 100; n++) begin
      run_xform("rand", rand_blk(n % 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
